systolic_skew_buffer: RTL and testbench

//  Parametrised multi-lane delay/skew buffer for the systolic array datapath.

---
 rtl/systolic_skew_buffer.sv | 96 +++++++++
 tb/tb_systolic_skew_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_buffer.sv
// systolic_skew_buffer
//   Multi-lane delay line that turns a row-aligned operand vector into a
//   diagonal wavefront (SKEW) or re-aligns a wavefront back into a row
//   (DESKEW). Every lane is a register chain of BASE_DELAY+LANES-1 stages.
//   The active mode selects which stage of each lane drives dout.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   en          shift enable (0 = stall, everything holds)
//   flush       synchronous clear of all stages and valids
//   mode        requested mode: 0 = SKEW, 1 = DESKEW
//   in_valid    din carries a valid vector this cycle
//   din         input vector, lane i at [i*DATA_W +: DATA_W]
//   dout        output vector, lane i at [i*DATA_W +: DATA_W]
//   dout_valid  per-lane valid of dout
//   busy        some valid word is still held in any stage
//   mode_q      active mode
//   mode_err    a mode change was refused at the last edge
module systolic_skew_buffer #(
  parameter int LANES      = 16,
  parameter int DATA_W     = 8,
  parameter int BASE_DELAY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] din,
  output logic [LANES*DATA_W-1:0] dout,
  output logic [LANES-1:0]        dout_valid,
  output logic                    busy,
  output logic                    mode_q,
  output logic                    mode_err
);

  localparam int STAGES = BASE_DELAY + LANES - 1;

  logic [LANES-1:0] lane_busy;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Stage s holds a word that was captured s+1 enabled cycles ago, so a
      // delay of D cycles is tapped at stage D-1.
      localparam int SKEW_TAP   = BASE_DELAY + gi - 1;
      localparam int DESKEW_TAP = BASE_DELAY + LANES - 2 - gi;

      logic [STAGES-1:0][DATA_W-1:0] data_reg;
      logic [STAGES-1:0]             valid_reg;
      logic [DATA_W-1:0]             din_lane;

      // Bubbles carry zero data so an invalid output lane always reads 0.
      assign din_lane = in_valid ? din[gi*DATA_W +: DATA_W] : '0;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg  <= '0;
          valid_reg <= '0;
        end else if (flush) begin
          data_reg  <= '0;
          valid_reg <= '0;
        end else if (en) begin
          data_reg  <= {data_reg[STAGES-2:0], din_lane};
          valid_reg <= {valid_reg[STAGES-2:0], in_valid};
        end
      end

      assign dout[gi*DATA_W +: DATA_W] = mode_q ? data_reg[DESKEW_TAP] : data_reg[SKEW_TAP];
      assign dout_valid[gi]            = mode_q ? valid_reg[DESKEW_TAP] : valid_reg[SKEW_TAP];
      assign lane_busy[gi]             = |valid_reg;
    end
  endgenerate

  assign busy = |lane_busy;

  // The tap selection may only move while the chains are empty and nothing
  // is entering; a flush empties them on the same edge, so it is also safe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= 1'b0;
      mode_err <= 1'b0;
    end else if (mode != mode_q) begin
      if ((!busy && !in_valid) || flush) begin
        mode_q   <= mode;
        mode_err <= 1'b0;
      end else begin
        mode_err <= 1'b1;
      end
    end else begin
      mode_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// tb_systolic_skew_buffer
//   Self-checking bench for systolic_skew_buffer with LANES=4, DATA_W=8,
//   BASE_DELAY=1. Every captured vector pushes one expected word per lane
//   (value and due enabled-cycle) into a per-lane queue; words are popped and
//   compared when they are due. A table of single-beat vectors checks exact
//   per-cycle lane timing; hand-written sequences cover stall, mode guard,
//   flush and reset.
module tb_systolic_skew_buffer;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int BASE   = 1;
  localparam int STAGES = BASE + LANES - 1;

  logic                    clk;
  logic                    reset_n;
  logic                    en;
  logic                    flush;
  logic                    mode;
  logic                    in_valid;
  logic [LANES*DATA_W-1:0] din;
  logic [LANES*DATA_W-1:0] dout;
  logic [LANES-1:0]        dout_valid;
  logic                    busy;
  logic                    mode_q;
  logic                    mode_err;

  systolic_skew_buffer #(
    .LANES      (LANES),
    .DATA_W     (DATA_W),
    .BASE_DELAY (BASE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .flush      (flush),
    .mode       (mode),
    .in_valid   (in_valid),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .mode_q     (mode_q),
    .mode_err   (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  typedef struct packed {
    logic                    mode;
    logic [LANES*DATA_W-1:0] din;
    logic [LANES-1:0][3:0]   lat;
  } vec_t;

  exp_t sb [LANES][$];

  int checks = 0;
  int errors = 0;
  int ec = 0;          // enabled-cycle count
  int cyc = 0;         // sampled cycles
  int last_cap = 0;    // enabled-cycle index of the last captured vector
  bit have_cap = 0;
  bit exp_mode = 0;
  bit exp_err = 0;
  int words = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input bit m, input int l);
    return m ? (BASE + LANES - 1 - l) : (BASE + l);
  endfunction

  function automatic bit busy_model();
    return have_cap && (ec <= last_cap + STAGES - 1);
  endfunction

  task automatic clear_model();
    for (int l = 0; l < LANES; l++) sb[l].delete();
    have_cap = 0;
  endtask

  // Apply current inputs across one rising edge, then sample #1 later.
  task automatic step();
    bit e_rst, e_flush, e_en, busy_pre;
    logic [LANES*DATA_W-1:0] prev_dout;
    logic [LANES-1:0]        prev_dv;
    exp_t e;
    e_rst     = !reset_n;
    e_flush   = flush;
    e_en      = en;
    prev_dout = dout;
    prev_dv   = dout_valid;
    if (e_rst) begin
      clear_model();
      exp_mode = 0;
      exp_err  = 0;
    end else begin
      busy_pre = busy_model();
      if (!flush && en && in_valid) begin
        for (int l = 0; l < LANES; l++) begin
          e.data = din[l*DATA_W +: DATA_W];
          e.due  = ec + lat_of(exp_mode, l);
          sb[l].push_back(e);
        end
        last_cap = ec + 1;
        have_cap = 1;
      end
      if (mode != exp_mode) begin
        if ((!busy_pre && !in_valid) || flush) begin
          exp_mode = mode;
          exp_err  = 0;
        end else begin
          exp_err = 1;
        end
      end else begin
        exp_err = 0;
      end
      if (flush) clear_model();
      else if (en) ec++;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("mode_q", {31'd0, mode_q}, {31'd0, exp_mode});
    check("mode_err", {31'd0, mode_err}, {31'd0, exp_err});
    check("busy", {31'd0, busy}, {31'd0, busy_model()});
    if (e_rst || e_flush || e_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (sb[l].size() > 0 && sb[l][0].due == ec) begin
          e = sb[l].pop_front();
          check("lane_valid", {31'd0, dout_valid[l]}, 32'd1);
          check("lane_data", {24'd0, dout[l*DATA_W +: DATA_W]}, {24'd0, e.data});
          words++;
          $display("cycle %0d lane %0d word %h (expected %h)", cyc, l, dout[l*DATA_W +: DATA_W], e.data);
        end else begin
          check("lane_idle_valid", {31'd0, dout_valid[l]}, 32'd0);
          check("lane_idle_data", {24'd0, dout[l*DATA_W +: DATA_W]}, 32'd0);
        end
      end
    end else begin
      check("stall_dout", dout, prev_dout);
      check("stall_valid", {28'd0, dout_valid}, {28'd0, prev_dv});
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    din = $urandom;
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, busy_fall, mode_rise;
    vec_t v;
    logic exp_v;
    logic [7:0] exp_d;

    vecs[0] = '{mode: 1'b0, din: 32'h44332211, lat: {4'd4, 4'd3, 4'd2, 4'd1}};
    vecs[1] = '{mode: 1'b1, din: 32'h44332211, lat: {4'd1, 4'd2, 4'd3, 4'd4}};
    vecs[2] = '{mode: 1'b0, din: 32'hA5FF0080, lat: {4'd4, 4'd3, 4'd2, 4'd1}};
    vecs[3] = '{mode: 1'b1, din: 32'h01020304, lat: {4'd1, 4'd2, 4'd3, 4'd4}};

    reset_n = 0; en = 1; flush = 0; mode = 0; in_valid = 0; din = '0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      din = $urandom;
      in_valid = ~in_valid;
      step();
      check("rst_dout", dout, 32'd0);
      check("rst_valid", {28'd0, dout_valid}, 32'd0);
    end
    reset_n = 1;
    idle(2);

    // Single-beat table: exact per-cycle lane timing in both modes.
    for (int t = 0; t < 4; t++) begin
      v = vecs[t];
      mode = v.mode;
      idle(2);
      check("tbl_mode_q", {31'd0, mode_q}, {31'd0, v.mode});
      din = v.din;
      in_valid = 1;
      step();
      in_valid = 0;
      for (int c = 1; c <= 6; c++) begin
        if (c > 1) step();
        for (int l = 0; l < LANES; l++) begin
          exp_v = (c == int'(v.lat[l]));
          exp_d = exp_v ? v.din[l*DATA_W +: DATA_W] : 8'd0;
          check("tbl_valid", {31'd0, dout_valid[l]}, {31'd0, exp_v});
          check("tbl_data", {24'd0, dout[l*DATA_W +: DATA_W]}, {24'd0, exp_d});
        end
        if (c >= 5) check("tbl_busy_low", {31'd0, busy}, 32'd0);
      end
    end

    // Stall: three back-to-back vectors, then en=0 for three cycles with
    // junk on din that must be dropped.
    mode = 0;
    idle(2);
    w0 = words;
    in_valid = 1;
    din = 32'h01010101; step();
    din = 32'h02020202; step();
    din = 32'h03030303; step();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      step();
    end
    en = 1;
    idle(8);
    check("stall_words", words - w0, 32'd12);

    // Mode guard: DESKEW requested while the SKEW chains hold a word.
    din = 32'h44332211;
    in_valid = 1;
    step();
    in_valid = 0;
    mode = 1;
    busy_fall = -1;
    mode_rise = -1;
    for (int i = 0; i < 20 && mode_rise < 0; i++) begin
      step();
      if (busy_fall < 0 && !busy) busy_fall = cyc;
      if (mode_rise < 0 && mode_q) mode_rise = cyc;
      if (busy) check("guard_mode_held", {31'd0, mode_q}, 32'd0);
    end
    check("guard_switch_time", mode_rise, busy_fall + 1);
    idle(2);

    // Flush at c2 of a single beat, with a mode change on the same edge.
    din = 32'h44332211;
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    flush = 1;
    mode = 0;
    in_valid = 1;
    din = 32'hDEADBEEF;
    step();
    flush = 0;
    in_valid = 0;
    check("flush_valid", {28'd0, dout_valid}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_mode_q", {31'd0, mode_q}, 32'd0);
    idle(6);

    // Reset pulse mid-flight.
    din = 32'h44332211;
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    reset_n = 0;
    #1;
    check("arst_valid", {28'd0, dout_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    step();
    reset_n = 1;
    idle(6);

    // Random streaming with stalls, in DESKEW.
    mode = 1;
    idle(2);
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      din = $urandom;
      step();
    end
    en = 1;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
